uart_transmitter: RTL and testbench
===================================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter: DELAY_FRAMES, default 234, clock cycles per UART bit; legal values 2..65535.
REQ-002 Parameter: FIFO_DEPTH, default 4, number of byte entries in the transmit FIFO; legal values are powers of two, 2..16.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: tx_data  input  8  byte to send.
REQ-006 Port: tx_valid  input  1  tx_data is valid this cycle.
REQ-007 Port: tx_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 Port: uart_tx  output  1  serial line, idle high, registered.
REQ-009 Port: tx_busy  output  1  high while the FSM is not IDLE or the FIFO is non-empty.
REQ-010 Port: fifo_level  output  clog2(FIFO_DEPTH)+1  number of bytes currently held in the FIFO.

Function
REQ-011 A byte shall be accepted on a rising edge where tx_valid && tx_ready is true; tx_data is then written at the FIFO tail.
REQ-012 tx_ready shall equal (fifo_level != FIFO_DEPTH), derived from the registered level only.
REQ-013 A pop in the same cycle does not raise tx_ready.
REQ-014 FIFO pointers shall wrap modulo FIFO_DEPTH.
REQ-015 fifo_level shall increment on push only, decrement on pop only, and stay unchanged on a simultaneous push and pop.
REQ-016 The FSM shall have the states IDLE, START, DATA and STOP.
REQ-017 An internal bit counter 0..DELAY_FRAMES-1 and a bit index 0..7 shall time the frame.
REQ-018 IDLE -> START: when fifo_level != 0, the FSM shall pop the head byte into a shift register, drive uart_tx=0 and clear the bit counter, all on the same edge.
REQ-019 START: uart_tx=0 for exactly DELAY_FRAMES cycles, then the FSM shall go to DATA with bit index 0.
REQ-020 DATA: uart_tx shall carry data bits LSB first, each for exactly DELAY_FRAMES cycles.
REQ-021 DATA: after bit 7, the FSM shall go to STOP.
REQ-022 STOP: uart_tx=1 for exactly DELAY_FRAMES cycles.
REQ-023 STOP end: if the FIFO is non-empty, the FSM shall pop and enter START directly (back-to-back frames, no extra idle cycles).
REQ-024 STOP end: if the FIFO is empty, the FSM shall enter IDLE.
REQ-025 Frame length shall be exactly 10*DELAY_FRAMES cycles: 1 start bit, 8 data bits, 1 stop bit, no parity.
REQ-026 Latency: a byte accepted on edge N into an empty FIFO with the FSM in IDLE shall produce the falling edge of uart_tx on edge N+1.
REQ-027 A push into an empty FIFO and the FSM's pop shall never coincide on the same entry; the FSM sees the level registered after the push.
REQ-028 A byte shall be latched into the shift register at pop, so later FIFO writes never corrupt the frame in progress.
REQ-029 uart_tx shall never glitch: it changes only on bit-counter rollover or on an IDLE/STOP -> START transition.

Reset
REQ-030 While rst=1 on a rising edge, the block shall set FSM=IDLE, uart_tx=1, counters=0, FIFO pointers=0, fifo_level=0, tx_ready=1 and tx_busy=0.
REQ-031 A tx_valid asserted in a cycle with rst=1 shall be ignored.
REQ-032 Reset mid-frame shall abort the frame: uart_tx=1 from the next edge, and all queued bytes are discarded.
REQ-033 The first accepted byte after reset shall start a complete new frame.

Verification (DELAY_FRAMES=8, FIFO_DEPTH=4)
REQ-034 Write 0x41 once while idle -> uart_tx falls 1 cycle after accept; line reads 0,1,0,0,0,0,0,1,0,1, each for 8 cycles (80 cycles total); tx_busy then drops.
REQ-035 Write 0xFF -> low for 8 cycles, then high for 72 cycles; write 0x00 -> low for 72 cycles, then high for 8 cycles.
REQ-036 Write 0x11, 0x22, 0x33 on consecutive cycles -> three frames totalling exactly 240 cycles with no idle gap; fifo_level peaks at 2.
REQ-037 Hold tx_valid high for 6 cycles (0xA0..0xA5) while the line is idle -> the first byte pops immediately and the FIFO reaches 4.
REQ-038 In the REQ-037 case, tx_ready goes low once the FIFO reaches 4, and 0xA5 is never accepted.
REQ-039 In the REQ-037 case, exactly five frames (0xA0..0xA4) are sent, and tx_ready returns high the cycle after the next pop.
REQ-040 Assert rst for 1 cycle during bit 3 of 0x5A with 2 bytes queued -> uart_tx=1 and fifo_level=0 on the next edge, with no further frames.
REQ-041 After the REQ-040 reset, a new write of 0xC3 sends a correct frame.
REQ-042 Checker: a UART receiver model sampling at bit centres shall recover every transmitted byte in order, across all scenarios.

Source files
------------

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter fed by a small byte FIFO.
// Frames leave back-to-back for as long as the FIFO holds data.
module uart_transmitter #(
   parameter int DELAY_FRAMES = 234,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [7:0]                  tx_data,
   input  logic                        tx_valid,
   output logic                        tx_ready,
   output logic                        uart_tx,
   output logic                        tx_busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CNT_W = $clog2(DELAY_FRAMES);
   localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DELAY_FRAMES - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [LVL_W-1:0] level_reg;
   logic [LVL_W-1:0] level_next;

   state_t           state_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [2:0]       bit_idx_reg;
   logic [7:0]       shift_reg;
   logic             tx_reg;

   logic             fifo_empty;
   logic             bit_done;
   logic             push;
   logic             pop;

   assign fifo_empty = (level_reg == '0);
   assign bit_done   = (cnt_reg == LAST_COUNT);

   // Readiness comes from the registered level only, so a pop never frees a slot in its own cycle.
   assign tx_ready = (level_reg != FULL_LEVEL);
   assign push     = !rst && tx_valid && tx_ready;
   assign pop      = !rst && !fifo_empty &&
                     ((state_reg == IDLE) || ((state_reg == STOP) && bit_done));

   assign uart_tx    = tx_reg;
   assign tx_busy    = (state_reg != IDLE) || !fifo_empty;
   assign fifo_level = level_reg;

   // Storage carries no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= tx_data;
      end
   end

   always_comb begin
      level_next = level_reg;
      case ({push, pop})
         2'b10:   level_next = level_reg + LVL_W'(1);
         2'b01:   level_next = level_reg - LVL_W'(1);
         default: level_next = level_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         level_reg <= level_next;
      end
   end

   // The head byte is copied into shift_reg at pop, isolating the frame from later FIFO writes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         tx_reg      <= 1'b1;
         cnt_reg     <= '0;
         bit_idx_reg <= '0;
         shift_reg   <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (!fifo_empty) begin
                  shift_reg <= mem[rd_ptr_reg];
                  tx_reg    <= 1'b0;
                  cnt_reg   <= '0;
                  state_reg <= START;
               end
            end
            START: begin
               if (bit_done) begin
                  cnt_reg     <= '0;
                  bit_idx_reg <= '0;
                  tx_reg      <= shift_reg[0];
                  shift_reg   <= {1'b0, shift_reg[7:1]};
                  state_reg   <= DATA;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            DATA: begin
               if (bit_done) begin
                  cnt_reg <= '0;
                  if (bit_idx_reg == 3'd7) begin
                     tx_reg    <= 1'b1;
                     state_reg <= STOP;
                  end else begin
                     bit_idx_reg <= bit_idx_reg + 3'd1;
                     tx_reg      <= shift_reg[0];
                     shift_reg   <= {1'b0, shift_reg[7:1]};
                  end
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            STOP: begin
               if (bit_done) begin
                  cnt_reg <= '0;
                  if (!fifo_empty) begin
                     shift_reg <= mem[rd_ptr_reg];
                     tx_reg    <= 1'b0;
                     state_reg <= START;
                  end else begin
                     state_reg <= IDLE;
                  end
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            default: begin
               state_reg <= IDLE;
               tx_reg    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter with DELAY_FRAMES=8, FIFO_DEPTH=4.
// A cycle table covers reset and a FIFO-filling burst; directed sequences cover frames, back-to-back and abort.
module tb_uart_transmitter;

   localparam int D = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic       uart_tx;
   logic       tx_busy;
   logic [2:0] fifo_level;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];

   uart_transmitter #(.DELAY_FRAMES(D), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .uart_tx    (uart_tx),
      .tx_busy    (tx_busy),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       valid;
      logic [7:0] data;
      logic       exp_tx;
      logic       exp_ready;
      logic       exp_busy;
      logic [2:0] exp_level;
   } vec_t;

   vec_t vecs[10];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (tx_busy !== 1'b0 && n < 2000) begin
         step();
         n++;
      end
   endtask

   task automatic send_frame(input logic [7:0] b);
      logic [9:0] fr;
      int bad;
      fr = {1'b1, b, 1'b0};
      tx_data  = b;
      tx_valid = 1'b1;
      exp_q.push_back(b);
      step();
      tx_valid = 1'b0;
      check($sformatf("frame_%02h_accept_level", b), fifo_level, 1);
      check($sformatf("frame_%02h_line_high_at_accept", b), uart_tx, 1);
      for (int bi = 0; bi < 10; bi++) begin
         bad = 0;
         for (int k = 0; k < D; k++) begin
            step();
            if (uart_tx !== fr[bi]) bad++;
         end
         check($sformatf("frame_%02h_bit%0d_bad_cycles", b, bi), bad, 0);
      end
      check($sformatf("frame_%02h_busy_in_stop", b), tx_busy, 1);
      step();
      check($sformatf("frame_%02h_busy_after", b), tx_busy, 0);
      $display("txn frame %02h done", b);
   endtask

   // Receiver model: samples each bit at its centre and checks bytes against exp_q in order.
   initial begin : rx_model
      bit active;
      int c;
      logic [7:0] sh;
      logic [7:0] want;
      active = 1'b0;
      c = 0;
      sh = '0;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            active = 1'b0;
         end else if (!active) begin
            if (uart_tx === 1'b0) begin
               active = 1'b1;
               c = 0;
            end
         end else begin
            c++;
            if (c == D / 2) begin
               check("rx_start_bit", uart_tx, 0);
            end else if (c >= D + D / 2 && c <= 8 * D + D / 2 && ((c - D / 2) % D) == 0) begin
               sh[(c - D - D / 2) / D] = uart_tx;
            end else if (c == 9 * D + D / 2) begin
               check("rx_stop_bit", uart_tx, 1);
               if (exp_q.size() == 0) begin
                  check("rx_unexpected_frame", {24'h0, sh}, 32'hFFFF_FFFF);
               end else begin
                  want = exp_q.pop_front();
                  check("rx_byte", sh, want);
                  $display("txn rx byte %02h", sh);
               end
               active = 1'b0;
            end
         end
      end
   end

   initial begin
      int n;
      int peak;
      int lows;

      // Rows 0-2: reset (with a write that must be ignored); rows 3-9: six-cycle burst A0..A5.
      vecs[0] = '{1'b1, 1'b1, 8'h99, 1'b1, 1'b1, 1'b0, 3'd0};
      vecs[1] = '{1'b1, 1'b1, 8'h98, 1'b1, 1'b1, 1'b0, 3'd0};
      vecs[2] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0};
      vecs[3] = '{1'b0, 1'b1, 8'hA0, 1'b1, 1'b1, 1'b1, 3'd1};
      vecs[4] = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 3'd1};
      vecs[5] = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 3'd2};
      vecs[6] = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 3'd3};
      vecs[7] = '{1'b0, 1'b1, 8'hA4, 1'b0, 1'b0, 1'b1, 3'd4};
      vecs[8] = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 3'd4};
      vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4};

      for (int i = 0; i < 5; i++) exp_q.push_back(8'hA0 + 8'(i));

      for (int i = 0; i < 10; i++) begin
         rst      = vecs[i].rst;
         tx_valid = vecs[i].valid;
         tx_data  = vecs[i].data;
         step();
         check($sformatf("vec%0d_uart_tx", i), uart_tx, vecs[i].exp_tx);
         check($sformatf("vec%0d_tx_ready", i), tx_ready, vecs[i].exp_ready);
         check($sformatf("vec%0d_tx_busy", i), tx_busy, vecs[i].exp_busy);
         check($sformatf("vec%0d_fifo_level", i), fifo_level, vecs[i].exp_level);
         $display("txn vec %0d rst=%0b valid=%0b data=%02h", i, vecs[i].rst, vecs[i].valid, vecs[i].data);
      end

      // First burst frame started on burst edge 2, so the next pop lands on burst edge 82.
      for (int j = 8; j <= 81; j++) step();
      check("burst_ready_before_pop", tx_ready, 0);
      check("burst_level_before_pop", fifo_level, 4);
      step();
      check("burst_ready_after_pop", tx_ready, 1);
      check("burst_level_after_pop", fifo_level, 3);
      check("burst_second_start", uart_tx, 0);
      wait_idle(n);
      check("burst_drain_cycles", n, 320);
      $display("txn burst drained after %0d cycles", n);

      send_frame(8'h41);
      send_frame(8'hFF);
      send_frame(8'h00);

      // Three consecutive writes: frames must abut and total exactly 240 cycles.
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h22);
      exp_q.push_back(8'h33);
      tx_valid = 1'b1;
      tx_data  = 8'h11;
      step();
      peak = fifo_level;
      tx_data = 8'h22;
      step();
      if (fifo_level > peak) peak = fifo_level;
      check("b2b_first_start", uart_tx, 0);
      tx_data = 8'h33;
      step();
      if (fifo_level > peak) peak = fifo_level;
      tx_valid = 1'b0;
      for (int j = 3; j <= 241; j++) begin
         step();
         if (fifo_level > peak) peak = fifo_level;
         if (j == 80)  check("b2b_stop1", uart_tx, 1);
         if (j == 81)  check("b2b_start2", uart_tx, 0);
         if (j == 160) check("b2b_stop2", uart_tx, 1);
         if (j == 161) check("b2b_start3", uart_tx, 0);
         if (j == 240) check("b2b_busy_last_stop", tx_busy, 1);
         if (j == 241) check("b2b_busy_after", tx_busy, 0);
      end
      check("b2b_level_peak", peak, 2);
      $display("txn back-to-back 11/22/33 done");

      // Abort: reset during data bit 3 of 0x5A with two bytes queued.
      tx_valid = 1'b1;
      tx_data  = 8'h5A;
      step();
      tx_data = 8'h01;
      step();
      tx_data = 8'h02;
      step();
      tx_valid = 1'b0;
      for (int j = 3; j <= 35; j++) begin
         step();
         if (j == 28) check("abort_5a_bit2", uart_tx, 0);
      end
      check("abort_level_queued", fifo_level, 2);
      rst      = 1'b1;
      tx_valid = 1'b1;
      tx_data  = 8'h77;
      exp_q.delete();
      step();
      rst      = 1'b0;
      tx_valid = 1'b0;
      check("abort_line_high", uart_tx, 1);
      check("abort_level_zero", fifo_level, 0);
      check("abort_ready", tx_ready, 1);
      check("abort_busy", tx_busy, 0);
      lows = 0;
      for (int j = 0; j < 100; j++) begin
         step();
         if (uart_tx !== 1'b1) lows++;
      end
      check("abort_no_more_frames", lows, 0);
      check("abort_level_still_zero", fifo_level, 0);
      $display("txn reset abort done");

      send_frame(8'hC3);
      repeat (4) step();
      check("rx_all_bytes_recovered", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
